logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one 8-bit bitwise logic unit (AND / NAND / NOT) between NREQ requesters.
//  Round-robin arbitration, valid/ready request and response handshakes.
//  Holds operands stable on the unit for a programmable settle time, then
//  captures the result and returns it to the granted requester.
//  Sits between ALU-level issue logic and the combinational logic-unit datapath.
// PARAMETERS
//  NREQ        2   number of requesters (2..4)
//  DW          8   operand/result width
//  SETTLE_CYC  1   cycles LU_A/LU_B/LU_OP are held before LU_Y is sampled (>=1)
// PORTS
//  CLK        in   1         clock, rising edge
//  RST_N      in   1         asynchronous reset, active low
//  REQ_VALID  in   NREQ      per-requester request valid
//  REQ_READY  out  NREQ      per-requester accept; one-hot or zero
//  REQ_OP     in   2*NREQ    packed opcode, requester i at [2i+1:2i]
//  REQ_A      in   DW*NREQ   packed operand A
//  REQ_B      in   DW*NREQ   packed operand B
//  RSP_VALID  out  NREQ      per-requester response valid; one-hot or zero
//  RSP_READY  in   NREQ      per-requester response accept
//  RSP_Y      out  DW        result, meaningful only while any RSP_VALID bit is set
//  LU_OP      out  2         opcode to logic unit: 00 AND, 01 NAND, 10 NOT A, 11 reserved
//  LU_A       out  DW        operand A to logic unit
//  LU_B       out  DW        operand B to logic unit
//  LU_Y       in   DW        logic unit result (combinational)
//  BUSY       out  1         high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE, RR pointer 0, grant 0, all operand/result regs 0.
//    Reset values: REQ_READY, RSP_VALID, RSP_Y, LU_*, BUSY = 0.
//  - States and transitions:
//    IDLE   -> SETTLE when any REQ_VALID is set.
//    SETTLE -> RESP when the settle count reaches 0.
//    RESP   -> IDLE on RSP_READY[g].
//  - IDLE: the RR arbiter picks the first valid requester at or above the pointer,
//    wrapping around. REQ_READY[g]=1 combinationally in the same cycle.
//    On that edge: latch OP/A/B, load cnt=SETTLE_CYC-1, go to SETTLE.
//  - SETTLE: LU_OP/LU_A/LU_B driven from the latched registers (stable, glitch-free).
//    When cnt==0: register LU_Y into RSP_Y and go to RESP. Otherwise decrement cnt.
//  - RESP: RSP_VALID[g]=1, RSP_Y held. On RSP_READY[g]: pointer=(g+1) mod NREQ, go to IDLE.
//    RSP_READY bits of other requesters are ignored.
//  - Latency: request accepted at edge t -> RSP_VALID high from edge t+SETTLE_CYC.
//    Minimum one idle cycle between responses.
//  - REQ_READY is 0 outside IDLE. No request is accepted while busy; there is no queueing.
//  - A requester may drop REQ_VALID before it is granted; no request is lost or duplicated.
//  - LU_OP=11 is forwarded unchanged; the result is whatever LU_Y returns.
//  - Pointer advances only on response completion, so an unserved requester
//    waits at most NREQ-1 transactions.
//  - Reset asserted mid-transaction: abort immediately, no response, all outputs to reset values.
//  - LU_* outputs return to 0 in IDLE.
// CONFIGURATION
//  LU_ZERO_FLAG_EN defined: adds output RSP_Z (1 bit).
//    RSP_Z = (LU_Y==0), captured with RSP_Y; reset value 0.
//  LU_ZERO_FLAG_EN undefined: port RSP_Z and its register do not exist.
// STRUCTURE
//  Package lu_arb_pkg:
//    lu_op_t enum: LU_AND=2'b00, LU_NAND=2'b01, LU_NOT=2'b10, LU_RSV=2'b11.
//    state_t enum: IDLE, SETTLE, RESP.
//    Constant LU_OPW=2.
//  Sub-module rr_arb2:
//    Generic NREQ round-robin arbiter (req, ptr -> one-hot gnt, gnt index).
//  Top contains the FSM, settle counter, operand and result registers.
// TESTING
//  1. Single request, req0 AND A=F0 B=3C, SETTLE_CYC=1 -> RSP_VALID[0] one edge
//     after accept, RSP_Y=30.
//  2. Both valid in the same cycle, ptr=0: req0 NAND A=FF B=0F, req1 NOT A=55
//     -> req0 served first (Y=F0), then req1 (Y=AA).
//  3. Back-to-back with both valid held for 4 transactions -> grants alternate 0,1,0,1.
//  4. RSP_READY held low 5 cycles -> RSP_VALID and RSP_Y stable, REQ_READY=0, BUSY=1 throughout.
//  5. SETTLE_CYC=3, RST_N pulsed low during SETTLE -> no RSP_VALID, all outputs 0,
//     next request served from ptr=0.
//  6. With LU_ZERO_FLAG_EN: AND A=0F B=F0 -> RSP_Y=00, RSP_Z=1; AND A=FF B=01 -> RSP_Z=0.

Source files
------------

// File: rtl/lu_arb_pkg.sv
// Shared types and constants for the logic-unit arbiter.
// Zero-flag option is controlled by the LU_ZERO_FLAG_EN macro in the top.
package lu_arb_pkg;

    localparam int unsigned LU_OPW = 2;

    typedef enum logic [LU_OPW-1:0] {
        LU_AND  = 2'b00,
        LU_NAND = 2'b01,
        LU_NOT  = 2'b10,
        LU_RSV  = 2'b11
    } lu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Round-robin arbiter: first requester at or above ptr wins, wrapping around.
module rr_arb2
    import lu_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = (32'(ptr) + k) % NREQ;
            if (!found && req[IW'(j)]) begin
                found          = 1'b1;
                gnt[IW'(j)]    = 1'b1;
                gnt_idx        = IW'(j);
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit between NREQ requesters with round-robin grant.
// Define LU_ZERO_FLAG_EN to add the rsp_z (result == 0) output.
module logic_unit_arbiter
    import lu_arb_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned DW         = 8,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [LU_OPW*NREQ-1:0] req_op,
    input  logic [DW*NREQ-1:0]     req_a,
    input  logic [DW*NREQ-1:0]     req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DW-1:0]          rsp_y,
`ifdef LU_ZERO_FLAG_EN
    output logic                   rsp_z,
`endif
    output lu_op_t                 lu_op,
    output logic [DW-1:0]          lu_a,
    output logic [DW-1:0]          lu_b,
    input  logic [DW-1:0]          lu_y,
    output logic                   busy
);

    localparam int unsigned IW = idx_w(NREQ);
    localparam int unsigned CW = idx_w(SETTLE_CYC);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_q;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;

    rr_arb2 #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Accept is combinational so the grant lands on the same edge as the capture.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE) begin
            req_ready = arb_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_q     <= '0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
`ifdef LU_ZERO_FLAG_EN
            rsp_z     <= 1'b0;
`endif
            lu_op     <= LU_AND;
            lu_a      <= '0;
            lu_b      <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt_q <= arb_idx;
                        lu_op <= lu_op_t'(req_op[32'(arb_idx) * LU_OPW +: LU_OPW]);
                        lu_a  <= req_a[32'(arb_idx) * DW +: DW];
                        lu_b  <= req_b[32'(arb_idx) * DW +: DW];
                        cnt   <= CW'(SETTLE_CYC - 1);
                        busy  <= 1'b1;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        rsp_y     <= lu_y;
`ifdef LU_ZERO_FLAG_EN
                        rsp_z     <= (lu_y == '0);
`endif
                        rsp_valid <= NREQ'(1) << gnt_q;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    // Pointer moves only on completion so waiting requesters keep their turn.
                    if (rsp_ready[gnt_q]) begin
                        rsp_valid <= '0;
                        ptr       <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
                        lu_op     <= LU_AND;
                        lu_a      <= '0;
                        lu_b      <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized and directed bench for logic_unit_arbiter against a transaction-level model.
// Define LU_ZERO_FLAG_EN to also check rsp_z.
module tb_logic_unit_arbiter;
    import lu_arb_pkg::*;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned DW     = 8;
    localparam int unsigned SETTLE = 3;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]      req_op;
    logic [15:0]     req_a, req_b;
    logic [7:0]      rsp_y, lu_a, lu_b, lu_y;
    lu_op_t          lu_op;
    logic            busy;
`ifdef LU_ZERO_FLAG_EN
    logic            rsp_z;
`endif

    int n_chk, n_pass;

    // transaction-level model state
    bit         m_busy;
    int         m_g, m_ptr, m_tacc, cyc;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b;

    logic_unit_arbiter #(.NREQ(NREQ), .DW(DW), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
`ifdef LU_ZERO_FLAG_EN
        .rsp_z(rsp_z),
`endif
        .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_y(lu_y),
        .busy(busy)
    );

    function automatic logic [7:0] lu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return ~(a & b);
            2'b10:   return ~a;
            default: return a ^ b;
        endcase
    endfunction

    assign lu_y = lu_fn(lu_op, lu_a, lu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (((v >> ((p + k) % NREQ)) & 2'b01) != 2'b00) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Compare outputs with the model for the state after the last edge, then advance it.
    task automatic check_cycle();
        int         w;
        logic [1:0] exp_ready, exp_rv;
        if (!rst_n) begin
            chk("reset_outs", 32'({req_ready, rsp_valid, rsp_y, lu_op, lu_a, lu_b, busy}), 32'd0);
`ifdef LU_ZERO_FLAG_EN
            chk("reset_rsp_z", 32'(rsp_z), 32'd0);
`endif
            m_busy = 1'b0;
            m_ptr  = 0;
            return;
        end
        w         = pick(req_valid, m_ptr);
        exp_ready = (!m_busy && w >= 0) ? 2'b01 << w : 2'b00;
        exp_rv    = (m_busy && cyc >= m_tacc + int'(SETTLE)) ? 2'b01 << m_g : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(m_busy));
        if (exp_rv != 2'b00) begin
            chk("rsp_y", 32'(rsp_y), 32'(lu_fn(m_op, m_a, m_b)));
`ifdef LU_ZERO_FLAG_EN
            chk("rsp_z", 32'(rsp_z), 32'(lu_fn(m_op, m_a, m_b) == 8'h00));
`endif
        end
        if (!m_busy) chk("lu_idle", 32'({lu_op, lu_a, lu_b}), 32'd0);
        else if (exp_rv == 2'b00) chk("lu_settle", 32'({lu_op, lu_a, lu_b}), 32'({m_op, m_a, m_b}));
        if (!m_busy && w >= 0) begin
            m_busy = 1'b1;
            m_g    = w;
            m_op   = req_op[2*w +: 2];
            m_a    = req_a[8*w +: 8];
            m_b    = req_b[8*w +: 8];
            m_tacc = cyc + 1;
        end else if (exp_rv != 2'b00 && ((rsp_ready >> m_g) & 2'b01) != 2'b00) begin
            m_busy = 1'b0;
            m_ptr  = (m_g + 1) % NREQ;
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic wait_rsp(output int idx, output int lat);
        lat = 0;
        idx = -1;
        while (rsp_valid == 2'b00 && lat < 40) begin
            tick();
            lat++;
        end
        if (rsp_valid == 2'b00) chk("rsp_timeout", 32'd0, 32'd1);
        else idx = rsp_valid[1] ? 1 : 0;
    endtask

    task automatic handshake(input int idx);
        rsp_ready = 2'b01 << idx;
        tick();
        rsp_ready = 2'b00;
    endtask

    initial begin
        int idx, lat;
        int exp_seq [4] = '{0, 1, 0, 1};
        n_chk = 0; n_pass = 0; cyc = 0; m_busy = 1'b0; m_ptr = 0;
        m_g = 0; m_tacc = 0; m_op = '0; m_a = '0; m_b = '0;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_op = '0; req_a = '0; req_b = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // single request, AND F0 & 3C
        set_req(0, 2'b00, 8'hF0, 8'h3C);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_rsp(idx, lat);
        chk("t1_latency", 32'(lat), 32'd3);
        chk("t1_idx", 32'(idx), 32'd0);
        chk("t1_y", 32'(rsp_y), 32'h30);
        handshake(0);
        tick();

        // reset during settle aborts the transaction
        set_req(1, 2'b00, 8'hFF, 8'hFF);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd0);
        chk("t5_lu", 32'({lu_op, lu_a, lu_b}), 32'd0);
        repeat (3) tick();
        req_valid = 2'b00;
        rst_n = 1'b1;
        repeat (5) tick();
        chk("t5_no_rsp", 32'(rsp_valid), 32'd0);

        // both valid, pointer back at 0
        set_req(0, 2'b01, 8'hFF, 8'h0F);
        set_req(1, 2'b10, 8'h55, 8'h00);
        req_valid = 2'b11;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        wait_rsp(idx, lat);
        chk("t2_first", 32'(idx), 32'd0);
        chk("t2_y0", 32'(rsp_y), 32'hF0);
        handshake(0);
        wait_rsp(idx, lat);
        req_valid = 2'b00;
        chk("t2_second", 32'(idx), 32'd1);
        chk("t2_y1", 32'(rsp_y), 32'hAA);
        handshake(1);

        // back-to-back alternation
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_rsp(idx, lat);
            chk("t3_grant", 32'(idx), 32'(exp_seq[n]));
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();

        // response back-pressure
        set_req(0, 2'b00, 8'hAA, 8'h0F);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        wait_rsp(idx, lat);
        for (int n = 0; n < 5; n++) begin
            chk("t4_valid", 32'(rsp_valid), 32'h1);
            chk("t4_y", 32'(rsp_y), 32'h0A);
            chk("t4_ready", 32'(req_ready), 32'd0);
            chk("t4_busy", 32'(busy), 32'd1);
            tick();
        end
        req_valid = 2'b00;
        handshake(0);

        // zero flag
        set_req(0, 2'b00, 8'h0F, 8'hF0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_rsp(idx, lat);
        chk("t6_y0", 32'(rsp_y), 32'h00);
`ifdef LU_ZERO_FLAG_EN
        chk("t6_z1", 32'(rsp_z), 32'd1);
`endif
        handshake(0);
        set_req(0, 2'b00, 8'hFF, 8'h01);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        wait_rsp(idx, lat);
        chk("t6_y1", 32'(rsp_y), 32'h01);
`ifdef LU_ZERO_FLAG_EN
        chk("t6_z0", 32'(rsp_z), 32'd0);
`endif
        handshake(0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            end
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
